apb_tan_sched: RTL
==================

# apb_tan_sched

Round-robin scheduler that shares one APB tangent peripheral between `N_REQ` requesters. For each granted request it sequences an APB write of the angle step to the control register, then an APB read of the result register. It returns the result to the requester that was granted. Sits between software-facing/compute requesters and the APB tangent slave as the only APB master on that segment.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `CTRL_ADDR`, 32'h0: APB address of the angle-step control register.
- `OUT_ADDR`, 32'h4: APB address of the tangent result register.
- `TIMEOUT_CYCLES`, 16: maximum ACCESS-phase cycles before abort. Used only with the timeout feature.

Ports:
- `PCLK`  in  1  clock; all logic on the rising edge.
- `PRESETn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  per-requester request.
- `req_x`  in  N_REQ*32  per-requester angle step; slice i is [32*i +: 32].
- `req_ready`  out  N_REQ  one-hot, one-cycle accept pulse.
- `rsp_valid`  out  N_REQ  one-hot, one-cycle result pulse to the owning requester.
- `rsp_data`  out  32  result; valid while any `rsp_valid` bit is high.
- `rsp_err`  out  1  timeout flag; qualified by `rsp_valid`.
- `busy`  out  1  high in every state except IDLE.
- `PSEL`, `PENABLE`, `PWRITE`  out  1  APB master controls.
- `PADDR`, `PWDATA`  out  32  APB address and write data.
- `PRDATA`  in  32  APB read data.
- `PREADY`  in  1  APB slave ready.

## Operation
- Reset values: every output is 0; round-robin pointer = 0; state = IDLE.
- States and transitions:
  - IDLE → WR_SETUP when any `req_valid` is set.
  - WR_SETUP → WR_ACCESS.
  - WR_ACCESS → RD_SETUP on `PREADY`.
  - RD_SETUP → RD_ACCESS.
  - RD_ACCESS → RESP on `PREADY`.
  - RESP → IDLE.
- Arbitration happens in IDLE only:
  - Grant goes to the first requester with `req_valid` set, searching from the pointer upward with wrap-around.
  - `req_ready[g]` pulses in that cycle.
  - `req_x[g]` and index g are registered.
  - The pointer becomes (g+1) mod N_REQ.
- A requester must hold `req_valid` and `req_x` until `req_ready`. Dropping `req_valid` before the grant withdraws the request.
- Write phase: `PADDR`=`CTRL_ADDR`, `PWRITE`=1, `PWDATA`=the registered x.
- Read phase: `PADDR`=`OUT_ADDR`, `PWRITE`=0, `PWDATA`=0.
- APB signal levels:
  - `PSEL` is 1 in the SETUP and ACCESS states.
  - `PENABLE` is 1 in the ACCESS states only.
  - `PADDR`, `PWRITE` and `PWDATA` are stable from SETUP through the completing ACCESS cycle.
- `PRDATA` is captured into `rsp_data` on the RD_ACCESS cycle where `PREADY`=1.
- RESP state: `rsp_valid[g]`=1 and `PSEL`=0 for one cycle. `rsp_data` is held until the next capture.
- Requests arriving while `busy` wait; at most one transaction is in flight.
- Reset mid-transaction: all outputs drop to 0 immediately. The in-flight request is lost and no `rsp_valid` is produced.
- `PREADY` seen in IDLE, SETUP or RESP is ignored.

## Timing
- Grant cycle = cycle 0; the arbiter adds no extra latency.
- With a slave that inserts one wait state per transfer (`PREADY` in the 2nd ACCESS cycle), the sequence is:
  - WR_SETUP in cycle 1.
  - WR_ACCESS in cycles 2–3.
  - RD_SETUP in cycle 4.
  - RD_ACCESS in cycles 5–6.
  - `rsp_valid` in cycle 7.
- With a zero-wait-state slave, `rsp_valid` is in cycle 5.
- Back-to-back throughput: the next grant is possible in the cycle after RESP, because IDLE lasts one cycle.
- Worst-case wait for a requester with all requesters active: N_REQ−1 full transactions.

## Configuration
- Macro: `APB_TAN_SCHED_TIMEOUT_EN`.
- When defined:
  - A counter runs in each ACCESS state.
  - If `PREADY` has not been seen after `TIMEOUT_CYCLES` ACCESS cycles, the FSM goes directly to RESP.
  - In that RESP: `rsp_err`=1, `rsp_data`=32'hFFFF_FFFF, `PSEL`/`PENABLE` deasserted.
  - A write-phase timeout skips the read phase.
  - The counter clears on entry to each ACCESS state.
- When not defined: the FSM waits on `PREADY` indefinitely, and `rsp_err` is tied to 0.

## Structure
- Package `apb_tan_pkg` holds:
  - the state enum `sched_state_t` (IDLE, WR_SETUP, WR_ACCESS, RD_SETUP, RD_ACCESS, RESP);
  - the constants `TAN_CTRL_ADDR`=32'h0 and `TAN_OUT_ADDR`=32'h4;
  - the timeout error pattern.
- Sub-module `rr_arbiter`:
  - parameterised by `N_REQ`;
  - request vector and advance strobe in;
  - one-hot grant and binary index out;
  - owns the pointer.
- The FSM and APB drive logic stay in `apb_tan_sched`.

## Test plan
- Reset then a single request: req 0 `req_x`=1; slave returns 1 → `req_ready[0]` in cycle 0, write of 1 to 0x0, read of 0x4, `rsp_valid[0]` with `rsp_data`=1 in cycle 7.
- All four requesters asserted with x=0,1,2,3:
  - grants occur in order 0,1,2,3;
  - results are 0, 1, 32'h7FFF_FFFF, 32'hFFFF_FFFE, each routed to the matching `rsp_valid` bit.
- Round-robin fairness: requesters 1 and 3 continuously valid, pointer=2 → grant order 3,1,3,1; no starvation.
- APB protocol checker across random wait states (0–5):
  - `PSEL`, `PADDR`, `PWRITE` stable through ACCESS;
  - `PENABLE` never high without `PSEL`;
  - exactly one write then one read per request.
- `PRESETn` asserted during RD_ACCESS:
  - all outputs are 0 in the same cycle;
  - no `rsp_valid` follows;
  - the next request completes normally.
- With `APB_TAN_SCHED_TIMEOUT_EN` and `PREADY` held at 0, `TIMEOUT_CYCLES`=16:
  - `rsp_valid` asserts with `rsp_err`=1 and `rsp_data`=32'hFFFF_FFFF after 16 WR_ACCESS cycles;
  - no read phase is issued.

Source files
------------

// File: rtl/apb_tan_pkg.sv
// Shared types and constants for the APB tangent scheduler.
package apb_tan_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_SETUP  = 3'd1,
    WR_ACCESS = 3'd2,
    RD_SETUP  = 3'd3,
    RD_ACCESS = 3'd4,
    RESP      = 3'd5
  } sched_state_t;

  localparam logic [31:0] TAN_CTRL_ADDR    = 32'h0000_0000;
  localparam logic [31:0] TAN_OUT_ADDR     = 32'h0000_0004;
  localparam logic [31:0] TAN_TIMEOUT_DATA = 32'hFFFF_FFFF;

  function automatic logic is_access(sched_state_t s);
    return (s == WR_ACCESS) || (s == RD_ACCESS);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first active request at or above the pointer,
// wrapping around; the pointer moves past the winner on an advance strobe.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_REQ-1:0] req_i,
  input  logic             adv_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IW-1:0]    idx_o,
  output logic             vld_o
);

  logic [IW-1:0] ptr_q, ptr_d;

  // Scan from the farthest offset down so the nearest active request wins.
  always_comb begin
    int j;
    j     = 0;
    idx_o = '0;
    vld_o = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr_q) + k) % N_REQ;
      if (req_i[j]) begin
        idx_o = IW'(j);
        vld_o = 1'b1;
      end
    end
    gnt_o = '0;
    if (vld_o) gnt_o[idx_o] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i && vld_o)
      ptr_d = (idx_o == IW'(N_REQ - 1)) ? '0 : idx_o + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/apb_tan_sched.sv
// Round-robin scheduler sharing one APB tangent slave: write angle step, read result.
// Optional ACCESS-phase timeout enabled by defining APB_TAN_SCHED_TIMEOUT_EN.
module apb_tan_sched
  import apb_tan_pkg::*;
#(
  parameter int          N_REQ          = 4,
  parameter logic [31:0] CTRL_ADDR      = TAN_CTRL_ADDR,
  parameter logic [31:0] OUT_ADDR       = TAN_OUT_ADDR,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*32-1:0] req_x,
  output logic [N_REQ-1:0]    req_ready,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [31:0]         rsp_data,
  output logic                rsp_err,
  output logic                busy,
  output logic                PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [31:0]         PADDR,
  output logic [31:0]         PWDATA,
  input  logic [31:0]         PRDATA,
  input  logic                PREADY
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  sched_state_t     state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [31:0]      x_q, x_d;
  logic [31:0]      data_q, data_d;
  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    gnt_idx;
  logic             gnt_vld;
  logic             idle;
  logic             tmo_hit;

  assign idle = (state_q == IDLE);

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk_i  (PCLK),
    .rst_ni (PRESETn),
    .req_i  (req_valid),
    .adv_i  (idle),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx),
    .vld_o  (gnt_vld)
  );

`ifdef APB_TAN_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_q;
  logic          err_q;

  // Counter is zero outside ACCESS, so it starts fresh on every ACCESS entry.
  assign tmo_hit = is_access(state_q) && !PREADY && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= is_access(state_q) ? tmo_q + 1'b1 : '0;
      if (idle)         err_q <= 1'b0;
      else if (tmo_hit) err_q <= 1'b1;
    end
  end

  assign rsp_err = (state_q == RESP) && err_q;
`else
  assign tmo_hit = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          state_d = WR_SETUP;
          idx_d   = gnt_idx;
          x_d     = req_x[32*int'(gnt_idx) +: 32];
        end
      end
      WR_SETUP: state_d = WR_ACCESS;
      WR_ACCESS: begin
        if (PREADY) begin
          state_d = RD_SETUP;
        end else if (tmo_hit) begin
          state_d = RESP;
          data_d  = TAN_TIMEOUT_DATA;
        end
      end
      RD_SETUP: state_d = RD_ACCESS;
      RD_ACCESS: begin
        if (PREADY) begin
          state_d = RESP;
          data_d  = PRDATA;
        end else if (tmo_hit) begin
          state_d = RESP;
          data_d  = TAN_TIMEOUT_DATA;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      x_q     <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      data_q  <= data_d;
    end
  end

  // APB controls decode straight from state, so they are stable SETUP through ACCESS.
  always_comb begin
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = '0;
    PWDATA  = '0;
    case (state_q)
      WR_SETUP, WR_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = (state_q == WR_ACCESS);
        PWRITE  = 1'b1;
        PADDR   = CTRL_ADDR;
        PWDATA  = x_q;
      end
      RD_SETUP, RD_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = (state_q == RD_ACCESS);
        PADDR   = OUT_ADDR;
      end
      default: ;
    endcase
  end

  // The grant is combinational, so gate it with reset to keep outputs quiet in reset.
  assign req_ready = (idle && PRESETn) ? gnt : '0;
  assign rsp_valid = (state_q == RESP) ? ({{(N_REQ-1){1'b0}}, 1'b1} << idx_q) : '0;
  assign rsp_data  = data_q;
  assign busy      = !idle;

endmodule
